// File: rtl/synapse_accum_if.sv
// synapse_accum_if: bus bundle for the synapse accumulator.
//   Parameters: N_INPUTS (presynaptic inputs), ADDR_W (weight address width).
//   start          request to begin an accumulation pass
//   in_spikes      presynaptic spike vector, sampled when start is accepted
//   w_we/w_addr/w_data  weight-file write port
//   post_synaptic  accumulated synaptic current, held between passes
//   valid          one-cycle pulse when post_synaptic updates
//   busy           high while a pass is in progress
// Modports: master drives requests and weights, slave is the accumulator.
interface synapse_accum_if #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned ADDR_W   = 3
);
  logic                start;
  logic [N_INPUTS-1:0] in_spikes;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_data;
  logic [7:0]          post_synaptic;
  logic                valid;
  logic                busy;

  modport master (
    output start, in_spikes, w_we, w_addr, w_data,
    input  post_synaptic, valid, busy
  );

  modport slave (
    input  start, in_spikes, w_we, w_addr, w_data,
    output post_synaptic, valid, busy
  );
endinterface

// File: rtl/synapse_accum.sv
// synapse_accum: weighted spike accumulator feeding a neuron's post_synaptic input.
//   On start (accepted only when idle) the spike vector is latched and one weight per
//   cycle is added for each set spike bit, saturating to 0..255. After N_INPUTS
//   accumulation cycles the result is copied to post_synaptic with a one-cycle valid
//   pulse, N_INPUTS+1 cycles after the accepting edge.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (clears state, outputs and weight file)
//   bus    synapse_accum_if.slave: start, in_spikes, w_we, w_addr, w_data,
//          post_synaptic, valid, busy
// Build option: define SYNAPSE_ACCUM_INHIBIT_EN to treat weights as two's complement
//   (negative weights subtract, accumulator clamps low at 0). Default is unsigned.
module synapse_accum #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input logic            clk,
  input logic            reset,
  synapse_accum_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_INPUTS - 1);

  logic [1:0]          state_q, state_d;
  logic [7:0]          weight_q [N_INPUTS];
  logic [N_INPUTS-1:0] spikes_q;
  logic [7:0]          acc_q, acc_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [7:0]          post_q;
  logic                valid_q;

  logic [7:0] cur_w;
  logic       cur_spike;
  logic [7:0] sat_sum;
  logic       accept;

  // Registered read: a write landing on the same edge does not affect this cycle's sum.
  assign cur_w     = weight_q[idx_q];
  assign cur_spike = spikes_q[idx_q];
  assign accept    = (state_q == StIdle) && bus.start;

`ifdef SYNAPSE_ACCUM_INHIBIT_EN
  logic signed [9:0] sum;
  always_comb begin
    sum = $signed({2'b00, acc_q}) + $signed({{2{cur_w[7]}}, cur_w});
    if (sum < 10'sd0) begin
      sat_sum = 8'd0;
    end else if (sum > 10'sd255) begin
      sat_sum = 8'hFF;
    end else begin
      sat_sum = sum[7:0];
    end
  end
`else
  logic [8:0] sum;
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, cur_w};
    sat_sum = sum[8] ? 8'hFF : sum[7:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAccum;
          acc_d   = 8'd0;
        end
      end
      StAccum: begin
        if (cur_spike) begin
          acc_d = sat_sum;
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= 8'd0;
      idx_q    <= '0;
      spikes_q <= '0;
      post_q   <= 8'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      // valid follows DONE by one edge so it coincides with the new post_synaptic value.
      valid_q <= (state_q == StDone);
      if (state_q == StDone) begin
        post_q <= acc_q;
      end
      if (accept) begin
        spikes_q <= bus.in_spikes;
        idx_q    <= '0;
      end else if (state_q == StAccum) begin
        idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Weight file: writable in any state; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weight_q[i] <= 8'd0;
      end
    end else if (bus.w_we && (32'(bus.w_addr) < N_INPUTS)) begin
      weight_q[bus.w_addr] <= bus.w_data;
    end
  end

  assign bus.post_synaptic = post_q;
  assign bus.valid         = valid_q;
  assign bus.busy          = (state_q == StAccum);

endmodule

// File: doc/synapse_accum.md
SYNAPSE_ACCUM -- requirements
Module: synapse_accum

Interface
REQ-001 Parameter N_INPUTS, default 8: number of presynaptic inputs, range 2..16.
REQ-002 Parameter ADDR_W, default 3: weight address width; SHALL equal ceil(log2(N_INPUTS)).
REQ-003 clk  input  1: single clock, rising edge; the block uses no other clock.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 start  input  1: one-cycle request to begin an accumulation pass.
REQ-006 in_spikes  input  N_INPUTS: presynaptic spike vector, sampled when start is accepted.
REQ-007 w_we  input  1: weight write enable.
REQ-008 w_addr  input  ADDR_W: weight write index.
REQ-009 w_data  input  8: weight write value.
REQ-010 post_synaptic  output  8: accumulated synaptic current, held between passes; feeds the neuron's post_synaptic input.
REQ-011 valid  output  1: one-cycle pulse when post_synaptic updates.
REQ-012 busy  output  1: high while a pass is in progress.

Function
REQ-013 Internal weight file: N_INPUTS x 8-bit registers; a write with w_we=1 SHALL take effect at the next rising edge, in any state.
REQ-014 FSM states: IDLE, ACCUM, DONE; IDLE->ACCUM on start=1; ACCUM->DONE after index N_INPUTS-1 is processed; DONE->IDLE unconditionally.
REQ-015 On start accepted in IDLE: latch in_spikes into a spike register, clear accumulator, clear index, assert busy on the next cycle.
REQ-016 ACCUM: one input per cycle at the current index; if the latched spike bit is 1, add weight[index] to the accumulator; then increment the index.
REQ-017 The weight read in ACCUM SHALL use the value stored before the edge; a simultaneous write to the same index does not affect that cycle's sum.
REQ-018 The accumulator SHALL be 8 bits and saturate at 255; it SHALL never wrap.
REQ-019 DONE: copy the accumulator to post_synaptic and pulse valid for exactly one cycle; busy is low in DONE.
REQ-020 Latency from the start edge to the valid pulse SHALL be N_INPUTS+1 cycles.
REQ-021 start asserted while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-022 post_synaptic SHALL hold its value until the next DONE; changes to in_spikes after acceptance have no effect on the pass.
REQ-023 An all-zero latched spike vector SHALL produce post_synaptic=0 with normal latency and a valid pulse.

Reset
REQ-024 reset=1 SHALL asynchronously force state=IDLE, post_synaptic=0, valid=0, busy=0, accumulator=0, index=0, spike register=0, all weights=0.
REQ-025 Reset asserted mid-pass SHALL abort the pass; no valid pulse is produced for the aborted pass.
REQ-026 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro SYNAPSE_ACCUM_INHIBIT_EN: when defined, weights are 8-bit two's complement; negative weights subtract; the accumulator saturates low at 0 and high at 255; post_synaptic stays unsigned 0..255.
REQ-028 Without SYNAPSE_ACCUM_INHIBIT_EN: weights are unsigned 0..255 and addition saturates only at 255.
REQ-029 Interface, FSM and latency SHALL be identical in both builds.

Verification
REQ-030 Weights w[i]=i+1, in_spikes=8'b1010_0101, start pulse -> valid after 9 cycles, post_synaptic=1+3+6+8=18.
REQ-031 All weights=100, in_spikes=8'hFF -> post_synaptic=255 (saturated), valid pulses exactly once.
REQ-032 start pulsed again at cycles 2 and 5 of a pass, with in_spikes changed -> single valid, result equals the original latched vector's sum.
REQ-033 Reset asserted at cycle 4 of a pass -> outputs 0 immediately, no valid; the next pass computes correctly.
REQ-034 INHIBIT_EN build: w0=50, w1=-80 (8'hB0), w2=20, in_spikes=3'b111 (others 0) -> 50, clamp to 0, then 20 -> post_synaptic=20.
REQ-035 Write w[3]=200 on the cycle index 3 is processed with old w[3]=10, spike bit 3 only -> post_synaptic=10; the next pass gives 200.
